// File: rtl/fetch_line_buffer.sv
// Single-line instruction fetch buffer: holds one 64-byte line and refills it
// over the system bus on a miss, delivering one instruction per request.
module fetch_line_buffer #(
  parameter int unsigned BUS_DATA_WIDTH    = 64,
  parameter int unsigned BUS_TAG_WIDTH     = 13,
  parameter int unsigned ADDRESS_WIDTH     = 64,
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG = 13'h1100
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_enable,
  input  logic [ADDRESS_WIDTH-1:0]     in_pc,
  input  logic                         in_flush,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction_bits,
  output logic [ADDRESS_WIDTH-1:0]     out_pc,
  output logic                         out_ready,
  output logic                         out_abtr_reqcyc,
  input  logic                         in_abtr_grant,
  output logic                         out_bus_busy,
  output logic                         out_bus_reqcyc,
  output logic                         out_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0]    out_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]     out_bus_reqtag,
  input  logic                         in_bus_respcyc,
  input  logic                         in_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0]    in_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]     in_bus_resptag
);

  localparam int unsigned LINE_BEATS = 8;
  localparam int unsigned TAG_W      = ADDRESS_WIDTH - 6;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    REQ,
    RESP,
    DELIVER
  } state_e;

  state_e                       state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]     pc_q, pc_d;
  logic [TAG_W-1:0]             tag_q, tag_d;
  logic                         valid_q, valid_d;
  logic [2:0]                   beat_cnt_q, beat_cnt_d;
  logic                         cancel_q, cancel_d;
  logic [INSTRUCTION_WIDTH-1:0] bits_q, bits_d;
  logic [ADDRESS_WIDTH-1:0]     last_pc_q, last_pc_d;
  logic [BUS_DATA_WIDTH-1:0]    line_q [LINE_BEATS];
  logic [BUS_DATA_WIDTH-1:0]    line_d [LINE_BEATS];

  logic                         hit;
  logic                         beat_accept;
  logic                         deliver_now;
  logic [BUS_DATA_WIDTH-1:0]    sel_beat;
  logic [INSTRUCTION_WIDTH-1:0] sel_insn;
  logic                         unused_resptag;

  // Responses are accepted in order regardless of tag.
  assign unused_resptag = ^in_bus_resptag;

  assign hit         = valid_q && (tag_q == in_pc[ADDRESS_WIDTH-1:6]);
  assign beat_accept = (state_q == RESP) && in_bus_respcyc;
  assign deliver_now = (state_q == DELIVER) && !in_flush;
  assign sel_beat    = line_q[pc_q[5:3]];
  assign sel_insn    = pc_q[2] ? sel_beat[2*INSTRUCTION_WIDTH-1:INSTRUCTION_WIDTH]
                               : sel_beat[INSTRUCTION_WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tag_d      = tag_q;
    valid_d    = valid_q;
    beat_cnt_d = beat_cnt_q;
    cancel_d   = cancel_q;
    bits_d     = bits_q;
    last_pc_d  = last_pc_q;
    line_d     = line_q;

    // A flush seen anywhere after acceptance only cancels delivery; the fill runs on.
    if (state_q != IDLE) begin
      cancel_d = cancel_q | in_flush;
    end

    case (state_q)
      IDLE: begin
        if (in_enable && !in_flush) begin
          pc_d     = in_pc;
          cancel_d = 1'b0;
          if (hit) begin
            state_d = DELIVER;
          end else begin
            state_d = ARB;
            valid_d = 1'b0;
          end
        end
      end
      ARB: begin
        if (in_abtr_grant) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (in_bus_reqack) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (beat_accept) begin
          line_d[beat_cnt_q] = in_bus_resp;
          beat_cnt_d         = beat_cnt_q + 3'd1;
          if (beat_cnt_q == 3'd7) begin
            valid_d = 1'b1;
            tag_d   = pc_q[ADDRESS_WIDTH-1:6];
            state_d = (cancel_q || in_flush) ? IDLE : DELIVER;
          end
        end
      end
      DELIVER: begin
        state_d = IDLE;
        if (deliver_now) begin
          bits_d    = sel_insn;
          last_pc_d = pc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      tag_q      <= '0;
      valid_q    <= 1'b0;
      beat_cnt_q <= '0;
      cancel_q   <= 1'b0;
      bits_q     <= '0;
      last_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      valid_q    <= valid_d;
      beat_cnt_q <= beat_cnt_d;
      cancel_q   <= cancel_d;
      bits_q     <= bits_d;
      last_pc_q  <= last_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  // Delivery is gated by the live flush, so the strobe and its data bypass the hold registers.
  assign out_ready            = deliver_now;
  assign out_pc               = deliver_now ? pc_q : last_pc_q;
  assign out_instruction_bits = deliver_now ? sel_insn : bits_q;

  assign out_abtr_reqcyc = (state_q == ARB);
  assign out_bus_busy    = (state_q == REQ) || (state_q == RESP);
  assign out_bus_reqcyc  = (state_q == REQ);
  assign out_bus_req     = (state_q == REQ) ? BUS_DATA_WIDTH'({pc_q[ADDRESS_WIDTH-1:6], 6'b0}) : '0;
  assign out_bus_reqtag  = (state_q == REQ) ? READ_TAG : '0;
  assign out_bus_respack = beat_accept;

endmodule

// File: doc/fetch_line_buffer.md
FETCH_LINE_BUFFER -- requirements
Module: fetch_line_buffer

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, bus beat width.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, bus tag width.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 64, address width.
REQ-004 SHALL have parameter INSTRUCTION_WIDTH, default 32, instruction width.
REQ-005 SHALL have parameter READ_TAG, default 13'h1100, tag driven on memory-read requests.
REQ-006 SHALL have ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_enable  in  1  fetch request valid.
- in_pc  in  64  address of requested instruction.
- in_flush  in  1  branch redirect; cancel pending delivery.
- out_instruction_bits  out  32  delivered instruction.
- out_pc  out  64  address of delivered instruction.
- out_ready  out  1  one-cycle delivery strobe.
- out_abtr_reqcyc  out  1  request to bus arbiter.
- in_abtr_grant  in  1  arbiter grant.
- out_bus_busy  out  1  bus owned by this block.
- out_bus_reqcyc / out_bus_respack  out  1 each  Sysbus request/response-ack.
- out_bus_req  out  BUS_DATA_WIDTH  request address.
- out_bus_reqtag  out  BUS_TAG_WIDTH  request tag.
- in_bus_respcyc / in_bus_reqack  in  1 each.
- in_bus_resp  in  BUS_DATA_WIDTH;  in_bus_resptag  in  BUS_TAG_WIDTH.

Function
REQ-007 SHALL hold one 64-byte line: 8 beats x 64 bits, line tag in_pc[63:6], valid bit.
REQ-008 SHALL implement states IDLE, ARB, REQ, RESP, DELIVER.
REQ-009 IDLE, in_enable=1, in_flush=0: SHALL latch in_pc; hit (valid, tag match) -> DELIVER; miss -> ARB.
REQ-010 ARB: SHALL hold out_abtr_reqcyc=1 until in_abtr_grant=1, then -> REQ.
REQ-011 REQ: SHALL drive out_bus_reqcyc=1, out_bus_req={pc[63:6],6'b0}, out_bus_reqtag=READ_TAG until in_bus_reqack=1, then -> RESP.
REQ-012 RESP: SHALL assert out_bus_respack combinationally equal to in_bus_respcyc; each accepted beat SHALL be written to beat index 0..7 in order; 3-bit counter wraps 7->0.
REQ-013 After beat 7: SHALL set valid, update tag, clear out_bus_busy, -> DELIVER.
REQ-014 out_bus_busy SHALL be 1 from grant through last beat inclusive.
REQ-015 DELIVER: SHALL pulse out_ready for exactly one cycle with out_pc=latched pc and out_instruction_bits = beat[pc[5:3]] upper half if pc[2]=1, else lower half; pc[1:0] ignored; -> IDLE.
REQ-016 Hit latency SHALL be 1 cycle (request cycle to out_ready); miss delivery SHALL occur the cycle after beat 7.
REQ-017 out_instruction_bits and out_pc SHALL hold last delivered value while out_ready=0.
REQ-018 in_flush in ARB or REQ SHALL NOT abort the bus transaction; fill completes, line is valid, DELIVER suppressed (no out_ready).
REQ-019 in_flush in RESP or DELIVER SHALL suppress that delivery; in_flush in IDLE SHALL block acceptance that cycle.
REQ-020 in_pc changes after acceptance SHALL be ignored until return to IDLE.

Reset
REQ-021 reset SHALL force IDLE, valid=0, counter=0, all outputs 0, overriding any in-flight fill.
REQ-022 After reset mid-RESP SHALL ignore in_bus_respcyc (respack=0) until a new request is granted.

Verification
REQ-023 Reset, release -> all outputs 0, state IDLE; in_enable with any pc -> out_abtr_reqcyc=1 next cycle (miss).
REQ-024 Miss pc=0x1008, grant at once, reqack next cycle, beats D0..D7 back-to-back -> out_bus_req=0x1000, tag 0x1100, 8 respacks, out_ready 1 cycle after D7 with bits=D1[31:0], out_pc=0x1008.
REQ-025 Then request pc=0x103C -> no bus activity, out_ready next cycle, bits=D7[63:32].
REQ-026 Grant delayed 5 cycles, in_pc toggled meanwhile -> out_bus_req unchanged line of latched pc, busy 0 until grant.
REQ-027 in_flush during beat 4 -> remaining beats acked, no out_ready, subsequent hit on same line delivers in 1 cycle.
REQ-028 reset at beat 3 -> outputs 0, valid=0, stray respcyc not acked, next request to same line misses.
